// File: rtl/address_request_arbiter_pkg.sv
// rtl/address_request_arbiter_pkg.sv - shared memory geometry, arbiter state encodings and defaults
package address_request_arbiter_pkg;

    // Memory geometry; an address is {col,row} with the column index in the MSBs.
    localparam int COLINDEXBITS = 4;
    localparam int ROWINDEXBITS = 4;
    localparam int WORDLENGTH   = 8;
    localparam int MEMNROWS     = 16;

    // Default number of address generators sharing the memory port.
    localparam int ARB_NREQ_DEFAULT = 4;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arbState_t;

endpackage

// File: rtl/address_request_arbiter_rr_pick.sv
// rtl/address_request_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Purpose: picks the first set request bit scanning rrPtr, rrPtr+1, ... mod NREQ.
// Ports:
//   request  [NREQ]   request vector
//   rrPtr    [IDBITS] highest-priority index this cycle (must be < NREQ)
//   grant    [NREQ]   one-hot grant, zero when nothing is requested
//   winner   [IDBITS] index of the granted bit (0 when nothing is requested)
//   anyValid          at least one request bit is set
module rr_pick #(
    parameter int NREQ   = 4,
    parameter int IDBITS = 2
) (
    input  logic [NREQ-1:0]   request,
    input  logic [IDBITS-1:0] rrPtr,
    output logic [NREQ-1:0]   grant,
    output logic [IDBITS-1:0] winner,
    output logic              anyValid
);

    int idx;

    // Scan from the lowest priority up so the last hit (closest to rrPtr) wins.
    always_comb begin
        idx      = 0;
        winner   = '0;
        anyValid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rrPtr) + k) % NREQ;
            if (request[idx]) begin
                winner   = IDBITS'(idx);
                anyValid = 1'b1;
            end
        end
        grant = anyValid ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;
    end

endmodule

// File: rtl/address_request_arbiter.sv
// rtl/address_request_arbiter.sv - round-robin memory address arbiter with burst locking
//
// Purpose: shares one registered address/strobe port between NREQ address generators.
// A granted requester keeps the port until it presents an address flagged reqLast.
// Optional feature macro: ARB_GRANT_COUNT_EN (per-requester 16-bit saturating accept counters).
// Ports:
//   clock, resetN            clock and synchronous active-low reset
//   reqValid/reqAddress/reqLast/reqReady  requester handshake (transfer = valid & ready)
//   storageReady             consumer can accept an address this cycle
//   address, newAddress      registered address and its one-cycle valid strobe
//   grantId                  requester index of the address on 'address'
//   busy                     high while a burst holds the port
//   grantCount, countClear   (ARB_GRANT_COUNT_EN only) accept counters and their clear
module address_request_arbiter
    import address_request_arbiter_pkg::*;
#(
    parameter int NREQ     = ARB_NREQ_DEFAULT,
    parameter int ADDRBITS = COLINDEXBITS + ROWINDEXBITS,
    parameter int IDBITS   = 2
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [NREQ-1:0]          reqValid,
    input  logic [NREQ*ADDRBITS-1:0] reqAddress,
    input  logic [NREQ-1:0]          reqLast,
    output logic [NREQ-1:0]          reqReady,
    input  logic                     storageReady,
    output logic [ADDRBITS-1:0]      address,
    output logic                     newAddress,
    output logic [IDBITS-1:0]        grantId,
`ifdef ARB_GRANT_COUNT_EN
    output logic [NREQ*16-1:0]       grantCount,
    input  logic                     countClear,
`endif
    output logic                     busy
);

    arbState_t         state;
    logic [IDBITS-1:0] rrPtr;
    logic [IDBITS-1:0] owner;
    logic [NREQ-1:0]   pickGrant;
    logic [IDBITS-1:0] pickWinner;
    logic              pickAny;
    logic [IDBITS-1:0] xferId;
    logic [IDBITS-1:0] nextPtr;
    logic              xfer;

    rr_pick #(
        .NREQ   (NREQ),
        .IDBITS (IDBITS)
    ) picker (
        .request  (reqValid),
        .rrPtr    (rrPtr),
        .grant    (pickGrant),
        .winner   (pickWinner),
        .anyValid (pickAny)
    );

    // While locked only the owner may be accepted; otherwise the picker decides.
    always_comb begin
        reqReady = '0;
        xferId   = pickWinner;
        if (state == ARB_LOCKED) begin
            xferId = owner;
            if (resetN && storageReady)
                reqReady = reqValid & ({{(NREQ-1){1'b0}}, 1'b1} << owner);
        end else if (resetN && storageReady && pickAny) begin
            reqReady = pickGrant;
        end
    end

    assign xfer    = |reqReady;
    // Wrap at NREQ, not at 2^IDBITS, so non-power-of-two NREQ never points at a ghost slot.
    assign nextPtr = (xferId == IDBITS'(NREQ - 1)) ? '0 : xferId + IDBITS'(1);
    assign busy    = (state == ARB_LOCKED);

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state      <= ARB_IDLE;
            rrPtr      <= '0;
            owner      <= '0;
            address    <= '0;
            newAddress <= 1'b0;
            grantId    <= '0;
        end else begin
            newAddress <= xfer;
            if (xfer) begin
                address <= reqAddress[xferId*ADDRBITS +: ADDRBITS];
                grantId <= xferId;
                if (reqLast[xferId]) begin
                    state <= ARB_IDLE;
                    rrPtr <= nextPtr;
                end else begin
                    state <= ARB_LOCKED;
                    owner <= xferId;
                end
            end
        end
    end

`ifdef ARB_GRANT_COUNT_EN
    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clock) begin
        if (!resetN || countClear) begin
            grantCount <= '0;
        end else if (xfer && (grantCount[xferId*16 +: 16] != 16'hFFFF)) begin
            grantCount[xferId*16 +: 16] <= grantCount[xferId*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_address_request_arbiter.sv
// tb/tb_address_request_arbiter.sv - self-checking bench for address_request_arbiter
module tb_address_request_arbiter;

    localparam int NREQ     = 4;
    localparam int ADDRBITS = 8;
    localparam int IDBITS   = 2;

    logic                     clock;
    logic                     resetN;
    logic [NREQ-1:0]          reqValid;
    logic [NREQ*ADDRBITS-1:0] reqAddress;
    logic [NREQ-1:0]          reqLast;
    logic [NREQ-1:0]          reqReady;
    logic                     storageReady;
    logic [ADDRBITS-1:0]      address;
    logic                     newAddress;
    logic [IDBITS-1:0]        grantId;
    logic                     busy;
    logic                     countClear;
`ifdef ARB_GRANT_COUNT_EN
    logic [NREQ*16-1:0]       grantCount;
`endif

    address_request_arbiter #(
        .NREQ     (NREQ),
        .ADDRBITS (ADDRBITS),
        .IDBITS   (IDBITS)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .reqValid     (reqValid),
        .reqAddress   (reqAddress),
        .reqLast      (reqLast),
        .reqReady     (reqReady),
        .storageReady (storageReady),
        .address      (address),
        .newAddress   (newAddress),
        .grantId      (grantId),
`ifdef ARB_GRANT_COUNT_EN
        .grantCount   (grantCount),
        .countClear   (countClear),
`endif
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner < 0 means nobody holds the port.
    int                  mOwner = -1;
    int                  mPtr   = 0;
    logic [ADDRBITS-1:0] mAddr  = '0;
    int                  mId    = 0;
    bit                  mNew   = 1'b0;
    int                  mCnt [NREQ];

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int firstFromPtr(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: drive, check reqReady, advance model, check registered outputs.
    task automatic stepCycle(input logic [NREQ-1:0] v, input logic [NREQ*ADDRBITS-1:0] a,
                             input logic [NREQ-1:0] l, input logic sr, input logic rn,
                             input logic clr, output int accepted);
        int win;
        logic [NREQ-1:0] expReady;
        @(negedge clock);
        reqValid = v; reqAddress = a; reqLast = l;
        storageReady = sr; resetN = rn; countClear = clr;
        #1;
        win = -1;
        if (rn && sr) begin
            if (mOwner < 0) win = firstFromPtr(v);
            else if (v[mOwner]) win = mOwner;
        end
        expReady = '0;
        if (win >= 0) expReady[win] = 1'b1;
        checkValue("reqReady", 64'(reqReady), 64'(expReady));

        if (!rn) begin
            mOwner = -1; mPtr = 0; mAddr = '0; mId = 0; mNew = 1'b0;
        end else begin
            mNew = (win >= 0);
            if (win >= 0) begin
                mAddr = a[win*ADDRBITS +: ADDRBITS];
                mId   = win;
                if (l[win]) begin
                    mOwner = -1;
                    mPtr   = (win + 1) % NREQ;
                end else begin
                    mOwner = win;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!rn || clr) mCnt[i] = 0;
            else if (i == win && mCnt[i] < 65535) mCnt[i]++;
        end

        @(posedge clock);
        #1;
        checkValue("newAddress", 64'(newAddress), 64'(mNew));
        checkValue("address", 64'(address), 64'(mAddr));
        checkValue("grantId", 64'(grantId), 64'(mId));
        checkValue("busy", 64'(busy), 64'(mOwner >= 0));
`ifdef ARB_GRANT_COUNT_EN
        for (int i = 0; i < NREQ; i++)
            checkValue("grantCount", 64'(grantCount[i*16 +: 16]), 64'(mCnt[i]));
`endif
        accepted = win;
    endtask

    logic [NREQ-1:0]          pv;
    logic [NREQ*ADDRBITS-1:0] pa;
    logic [NREQ-1:0]          pl;
    int acc;

    initial begin
        for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
        resetN = 1'b0; reqValid = '0; reqAddress = '0; reqLast = '0;
        storageReady = 1'b0; countClear = 1'b0;

        // Reset held with every requester asking.
        for (int k = 0; k < 3; k++) begin
            stepCycle(4'b1111, 32'h31211101, 4'b1111, 1'b1, 1'b0, 1'b0, acc);
            checkValue("resetReady", 64'(reqReady), 64'd0);
        end

        // Round-robin with single-address bursts.
        for (int k = 0; k < 8; k++) begin
            stepCycle(4'b1111, 32'h31211101, 4'b1111, 1'b1, 1'b1, 1'b0, acc);
            checkValue("rrGrant", 64'(grantId), 64'(k % 4));
            checkValue("rrNew", 64'(newAddress), 64'd1);
        end

        // Burst lock: move the pointer to 2, then req2 bursts 84,83,88 while req0 waits.
        stepCycle(4'b0010, 32'h00005500, 4'b0010, 1'b1, 1'b1, 1'b0, acc);
        stepCycle(4'b0101, 32'h00840007, 4'b0001, 1'b1, 1'b1, 1'b0, acc);
        checkValue("burst1", 64'(address), 64'h84);
        stepCycle(4'b0101, 32'h00830007, 4'b0001, 1'b1, 1'b1, 1'b0, acc);
        checkValue("burst2", 64'(address), 64'h83);
        checkValue("burstBusy", 64'(busy), 64'd1);
        stepCycle(4'b0101, 32'h00880007, 4'b0101, 1'b1, 1'b1, 1'b0, acc);
        checkValue("burst3", 64'(address), 64'h88);
        stepCycle(4'b1001, 32'h09000007, 4'b1001, 1'b1, 1'b1, 1'b0, acc);
        checkValue("afterBurst", 64'(grantId), 64'd3);

        // Backpressure mid-burst on req1.
        stepCycle(4'b0010, 32'h00004100, 4'b0000, 1'b1, 1'b1, 1'b0, acc);
        stepCycle(4'b0010, 32'h00004200, 4'b0000, 1'b0, 1'b1, 1'b0, acc);
        checkValue("stallNew", 64'(newAddress), 64'd0);
        stepCycle(4'b0010, 32'h00004200, 4'b0000, 1'b0, 1'b1, 1'b0, acc);
        checkValue("stallAddr", 64'(address), 64'h41);
        stepCycle(4'b0010, 32'h00004200, 4'b0000, 1'b1, 1'b1, 1'b0, acc);
        checkValue("stallBusy", 64'(busy), 64'd1);
        stepCycle(4'b0010, 32'h00004300, 4'b0010, 1'b1, 1'b1, 1'b0, acc);

        // Reset while locked to req1.
        stepCycle(4'b0010, 32'h00005100, 4'b0000, 1'b1, 1'b1, 1'b0, acc);
        stepCycle(4'b0010, 32'h00005200, 4'b0000, 1'b1, 1'b0, 1'b0, acc);
        checkValue("midResetBusy", 64'(busy), 64'd0);
        stepCycle(4'b0011, 32'h00005261, 4'b0011, 1'b1, 1'b1, 1'b0, acc);
        checkValue("postResetGrant", 64'(grantId), 64'd0);

`ifdef ARB_GRANT_COUNT_EN
        stepCycle(4'b0000, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1, acc);
        for (int k = 0; k < 5; k++)
            stepCycle(4'b0010, 32'h00007000, 4'b0010, 1'b1, 1'b1, 1'b0, acc);
        checkValue("count5", 64'(grantCount[16 +: 16]), 64'd5);
        stepCycle(4'b0010, 32'h00007000, 4'b0010, 1'b1, 1'b1, 1'b1, acc);
        checkValue("countClr", 64'(grantCount[16 +: 16]), 64'd0);
`endif

        // Randomized requesters obeying the hold-while-pending rule.
        pv = '0; pa = '0; pl = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        pv[i] = 1'b1;
                        pa[i*ADDRBITS +: ADDRBITS] = ADDRBITS'($urandom);
                        pl[i] = ($urandom_range(0, 2) == 0);
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            stepCycle(pv, pa, pl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0),
                      ($urandom_range(0, 39) == 0), acc);
            if (acc >= 0) pv[acc] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/address_request_arbiter.md
Name: address_request_arbiter

Overview:
Shares the single memory address/strobe interface (address, newAddress, storageReady) between NREQ address generators, such as pattern counters and readback sequencers.
- Round-robin arbitration with burst locking: a granted requester keeps the port until it flags its last address.
- Issues at most one address per cycle, with registered outputs, into the memory-side consumer.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDRBITS, 8, address width = COLINDEXBITS+ROWINDEXBITS ({col,row} packed, col in MSBs)
IDBITS, 2, width of grantId; must equal clog2(NREQ)

Ports:
clock  input  1  system clock, all logic on posedge
resetN  input  1  synchronous active-low reset
reqValid  input  NREQ  requester i has an address pending
reqAddress  input  NREQ*ADDRBITS  requester i address at bits [i*ADDRBITS +: ADDRBITS]
reqLast  input  NREQ  address from requester i is the last of its burst
reqReady  output  NREQ  combinational accept strobe; transfer when reqValid[i]&reqReady[i]
storageReady  input  1  consumer can take an address this cycle
address  output  ADDRBITS  registered address to memory
newAddress  output  1  one-cycle pulse: address is valid this cycle
grantId  output  IDBITS  index of the requester whose address is on address
busy  output  1  high while FSM in LOCKED

Behaviour:
- Reset (resetN=0 at posedge): address=0, newAddress=0, grantId=0, busy=0, state=IDLE, rrPtr=0. Takes effect even mid-burst; the burst is abandoned.
- reqReady is all-zero whenever storageReady=0 or resetN=0. It is at most one-hot.
- State IDLE:
  - When storageReady=1 and any reqValid is set, choose the first set bit scanning rrPtr, rrPtr+1, ... mod NREQ. That bit's reqReady is 1 this cycle.
  - If the chosen reqLast=1, stay in IDLE and set rrPtr=winner+1 mod NREQ.
  - Otherwise go to LOCKED with owner=winner.
- State LOCKED:
  - Only owner can be accepted. reqReady[owner]=storageReady&reqValid[owner].
  - Other requesters are starved until the burst ends.
  - A transfer with reqLast[owner]=1 returns to IDLE and sets rrPtr=owner+1 mod NREQ.
  - If the owner deasserts reqValid, the FSM holds LOCKED and idles. It does not time out.
- Output latency: one cycle. A transfer at edge N gives address=reqAddress[winner], grantId=winner and newAddress=1 after edge N.
  - newAddress returns to 0 on the next edge unless another transfer occurs. Back-to-back transfers give newAddress high continuously with a new address each cycle.
  - address and grantId hold their last value when no transfer occurs.
- Requester rule: reqAddress/reqLast must be stable while reqValid=1 and not yet accepted. The arbiter does not buffer.
- Simultaneous events:
  - storageReady drop while LOCKED: no transfer, state unchanged.
  - A new reqValid from a non-owner while LOCKED is ignored until IDLE.
- Single-requester case: a requester with repeated single-address bursts gets a grant every cycle. rrPtr wraps to itself via others when idle.
- No arithmetic on addresses; pass-through only. rrPtr increment wraps at NREQ, not at 2^IDBITS.

Optional Feature:
ARB_GRANT_COUNT_EN
- Defined:
  - Adds output grantCount [NREQ*16]: per-requester count of accepted addresses, 16-bit each, saturating at 16'hFFFF.
  - Adds input countClear, which zeroes all counters synchronously. countClear wins over a simultaneous increment.
  - resetN also clears the counters.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- MyParameters.vh supplies COLINDEXBITS, ROWINDEXBITS, WORDLENGTH, MEMNROWS. Add ARB_IDLE/ARB_LOCKED state encodings and the default NREQ there.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: request vector, rrPtr.
  - Outputs: one-hot grant, winner index, anyValid.
  - Reused by later memory-port arbiters.

Test Plan:
- Reset: hold resetN=0 for 3 cycles with reqValid=4'b1111 -> reqReady=0, newAddress=0, address=0, busy=0 throughout.
- Round-robin: storageReady=1, reqValid=4'b1111, reqLast=4'b1111, req i address=8'h10*i+1 -> newAddress high 4 consecutive cycles. Addresses 01,11,21,31, grantId 0,1,2,3, then repeats 01.
- Burst lock: req2 sends 3 addresses 8'h84, 8'h83, 8'h88 (last on third) while req0 is valid -> req0 not accepted until after 8'h88. busy=1 for 2 cycles. Next grant is req3 if valid, else req0.
- Backpressure: storageReady toggles 1,0,0,1 mid-burst -> only 2 transfers, address held, newAddress=0 in stalled cycles, state stays LOCKED.
- Reset mid-burst: resetN=0 one cycle while LOCKED to req1 -> busy=0, rrPtr=0. Next grant goes to req0 if valid.
- ARB_GRANT_COUNT_EN: 5 accepts from req1 -> grantCount[1]=5. countClear together with a req1 accept -> grantCount[1]=0.
